// File: rtl/minne_ctrl.sv
// Sequential access controller for the 8-bit word memory array: accepts one
// request at a time, strobes the addressed word, and returns a response.
module minne_ctrl #(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned WR_CYCLES = 1,
   parameter int unsigned RD_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [7:0]             req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_write,
   output logic [7:0]             rsp_rdata,
   output logic [(2**ADDR_W)-1:0] mem_sel,
   output logic                   mem_rw,
   output logic [7:0]             mem_din,
   input  logic [7:0]             mem_dout
);

   localparam int unsigned SEL_W = 2**ADDR_W;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
   logic [7:0]        lat_wdata, lat_wdata_nx;
   logic              req_ready_nx, rsp_valid_nx, rsp_write_nx, mem_rw_nx;
   logic [7:0]        rsp_rdata_nx, mem_din_nx;
   logic [SEL_W-1:0]  mem_sel_nx;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         mem_sel   <= '0;
         mem_rw    <= 1'b0;
         mem_din   <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         lat_addr  <= lat_addr_nx;
         lat_wdata <= lat_wdata_nx;
         req_ready <= req_ready_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_write <= rsp_write_nx;
         rsp_rdata <= rsp_rdata_nx;
         mem_sel   <= mem_sel_nx;
         mem_rw    <= mem_rw_nx;
         mem_din   <= mem_din_nx;
      end
   end

   // Next state and next values of every registered output
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      lat_addr_nx  = lat_addr;
      lat_wdata_nx = lat_wdata;
      req_ready_nx = req_ready;
      rsp_valid_nx = rsp_valid;
      rsp_write_nx = rsp_write;
      rsp_rdata_nx = rsp_rdata;
      mem_sel_nx   = mem_sel;
      mem_rw_nx    = mem_rw;
      mem_din_nx   = mem_din;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               lat_addr_nx  = req_addr;
               lat_wdata_nx = req_wdata;
               req_ready_nx = 1'b0;
               mem_sel_nx   = SEL_W'(1) << req_addr;
               if (req_write) begin
                  state_nx   = WRITE;
                  cnt_nx     = CNT_W'(WR_CYCLES - 1);
                  mem_rw_nx  = 1'b1;
                  mem_din_nx = req_wdata;
               end else begin
                  state_nx   = READ;
                  cnt_nx     = CNT_W'(RD_CYCLES - 1);
                  mem_rw_nx  = 1'b0;
                  mem_din_nx = '0;
               end
            end
         end
         WRITE: begin
            if (cnt == '0) begin
               state_nx     = RESP;
               mem_sel_nx   = '0;
               mem_rw_nx    = 1'b0;
               mem_din_nx   = '0;
               rsp_valid_nx = 1'b1;
               rsp_write_nx = 1'b1;
               rsp_rdata_nx = lat_wdata;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         READ: begin
            // Array data is sampled on the edge that ends the last strobe cycle
            if (cnt == '0) begin
               state_nx     = RESP;
               mem_sel_nx   = '0;
               mem_rw_nx    = 1'b0;
               mem_din_nx   = '0;
               rsp_valid_nx = 1'b1;
               rsp_write_nx = 1'b0;
               rsp_rdata_nx = mem_dout;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nx     = IDLE;
               rsp_valid_nx = 1'b0;
               req_ready_nx = 1'b1;
            end
         end
         default: begin
            state_nx     = IDLE;
            req_ready_nx = 1'b1;
            rsp_valid_nx = 1'b0;
            mem_sel_nx   = '0;
            mem_rw_nx    = 1'b0;
            mem_din_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_minne_ctrl.sv
// Directed and randomised bench for minne_ctrl with a behavioural word array
// and a response scoreboard.
module tb_minne_ctrl;

   localparam int WR = 3;
   localparam int RD = 2;

   typedef struct packed {
      logic       w;
      logic [7:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, clr, started;
   logic        req_valid, req_ready, req_write;
   logic [3:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [7:0]  rsp_rdata;
   logic [15:0] mem_sel;
   logic        mem_rw;
   logic [7:0]  mem_din, mem_dout;

   logic [7:0]  arr [16];
   logic [7:0]  ref_mem [16];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   minne_ctrl #(.ADDR_W(4), .WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata),
      .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Memory array: words write on a rising edge while selected with rw=1,
   // unselected words drive zero onto the shared output
   always @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         if (clr) arr[i] <= 8'h00;
         else if (mem_sel[i] && mem_rw) arr[i] <= mem_din;
      end
   end

   always_comb begin
      mem_dout = 8'h00;
      for (int i = 0; i < 16; i++)
         if (mem_sel[i] && !mem_rw) mem_dout = mem_dout | arr[i];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Strobe invariants checked every cycle outside reset
   always @(negedge clk) begin
      if (started && !rst) begin
         check("sel_onehot", 32'($countones(mem_sel) <= 1), 32'd1);
         if (mem_rw) check("rw_needs_sel", 32'($countones(mem_sel)), 32'd1);
         else        check("din_zero", 32'(mem_din), 32'd0);
      end
   end

   task automatic op(input logic w, input logic [3:0] a, input logic [7:0] d, input int hold);
      exp_t        e;
      int          lat;
      logic [15:0] sel_e;
      sel_e = 16'(1) << a;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      @(posedge clk);
      e.w = w;
      e.d = w ? d : ref_mem[a];
      sb.push_back(e);
      if (w) ref_mem[a] = d;
      @(negedge clk);
      // Garbage while busy must be ignored
      req_write = ~w; req_addr = a + 4'd1; req_wdata = ~d;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         check("strobe_sel", 32'(mem_sel), 32'(sel_e));
         check("strobe_rw", 32'(mem_rw), 32'(w));
         check("strobe_din", 32'(mem_din), w ? 32'(d) : 32'd0);
         check("busy_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      req_valid = 1'b0;
      check("latency", 32'(lat), w ? 32'(WR + 1) : 32'(RD + 1));
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_sel", 32'(mem_sel), 32'd0);
         check("bp_rdata", 32'(rsp_rdata), 32'(e.d));
         @(negedge clk);
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_write", 32'(rsp_write), 32'(e.w));
      check("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("back_idle_ready", 32'(req_ready), 32'd1);
      check("back_idle_valid", 32'(rsp_valid), 32'd0);
      check("back_idle_sel", 32'(mem_sel), 32'd0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b1; started = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0; req_wdata = 8'h00;
      rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; clr = 1'b0; started = 1'b1;

      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_write", 32'(rsp_write), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_mem_sel", 32'(mem_sel), 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd0);
      check("rst_mem_din", 32'(mem_din), 32'd0);

      op(1'b0, 4'd0, 8'h00, 0);
      op(1'b1, 4'd3, 8'b01010101, 0);
      op(1'b0, 4'd3, 8'h00, 0);
      check("ref_addr3_55", 32'(ref_mem[3]), 32'h55);
      op(1'b1, 4'd3, 8'b10100000, 0);
      op(1'b1, 4'd5, 8'hFF, 0);
      op(1'b0, 4'd3, 8'h00, 0);
      op(1'b0, 4'd5, 8'h00, 0);
      op(1'b0, 4'd3, 8'h00, 5);

      // Reset during the first write cycle; write data equals stored data
      req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = ref_mem[9];
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("midwr_sel", 32'(mem_sel), 32'h0200);
      check("midwr_rw", 32'(mem_rw), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_sel", 32'(mem_sel), 32'd0);
      check("rst_mid_rw", 32'(mem_rw), 32'd0);
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      op(1'b0, 4'd5, 8'h00, 0);

      for (int n = 0; n < 200; n++)
         op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom), int'($urandom_range(0, 2)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
